// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared types and helpers for the cve2 power controller
package cve2_pkg;

  typedef enum logic [1:0] {
    PWR_OFF    = 2'd0,
    PWR_ACTIVE = 2'd1,
    PWR_HOLD   = 2'd2,
    PWR_SLEEP  = 2'd3
  } pwr_state_e;

  // Hold counter needs at least one bit even when no hysteresis is configured.
  function automatic int unsigned hold_width(input int unsigned hold);
    return (hold > 0) ? $clog2(hold + 1) : 1;
  endfunction

endpackage

// File: rtl/cve2_clock_gate.sv
// rtl/cve2_clock_gate.sv - latch-based clock gate with scan override
module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Enable is captured while the clock is low so the gated clock cannot glitch.
  always_latch begin
    if (!clk_i) begin
      en_latch <= en_i | test_en_i;
    end
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cve2_pwr_hart_ctrl.sv
// rtl/cve2_pwr_hart_ctrl.sv - single-hart fetch enable, idle hysteresis and sleep accounting
module cve2_pwr_hart_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned IdleHoldCycles    = 0,
  parameter bit          FetchEnableSticky = 1'b1,
  parameter int unsigned CntWidth          = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_enable_i,
  input  logic                core_busy_i,
  input  logic                irq_pending_i,
  input  logic                irq_nm_i,
  input  logic                debug_req_i,
  input  logic                cnt_clr_i,
  output logic                clk_en_o,
  output logic                fetch_enable_o,
  output logic                core_sleep_o,
  output logic                wake_o,
  output pwr_state_e          pwr_state_o,
  output logic [CntWidth-1:0] sleep_cycles_o
);

  localparam int unsigned      HoldW    = hold_width(IdleHoldCycles);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(IdleHoldCycles);

  logic                fetch_q;
  logic                busy_q;
  logic                sleep_q;
  logic [HoldW-1:0]    hold_cnt;
  logic [CntWidth-1:0] sleep_cnt;

  logic wake;
  logic hold_active;
  logic fetch_d;
  logic drain_done;

  assign wake        = irq_pending_i | irq_nm_i | debug_req_i;
  assign hold_active = (hold_cnt != '0);

  // Non-sticky fetch enable only drops once the core has drained (busy_q low).
  assign fetch_d    = fetch_enable_i | (fetch_q & (FetchEnableSticky || busy_q));
  assign drain_done = fetch_q & ~fetch_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_q   <= 1'b0;
      busy_q    <= 1'b0;
      sleep_q   <= 1'b0;
      hold_cnt  <= '0;
      sleep_cnt <= '0;
    end else begin
      busy_q  <= core_busy_i;
      fetch_q <= fetch_d;
      sleep_q <= core_sleep_o;

      if (drain_done) begin
        hold_cnt <= '0;
      end else if (fetch_q && (busy_q || wake)) begin
        hold_cnt <= HoldLoad;
      end else if (hold_active) begin
        hold_cnt <= hold_cnt - HoldW'(1);
      end

      if (cnt_clr_i) begin
        sleep_cnt <= '0;
      end else if (core_sleep_o && (sleep_cnt != '1)) begin
        sleep_cnt <= sleep_cnt + CntWidth'(1);
      end
    end
  end

  // Wake sources reopen the clock combinationally but never while the hart is off.
  assign clk_en_o       = fetch_q & (busy_q | wake | hold_active);
  assign core_sleep_o   = fetch_q & ~clk_en_o;
  assign wake_o         = sleep_q & clk_en_o;
  assign fetch_enable_o = fetch_q;
  assign sleep_cycles_o = sleep_cnt;

  always_comb begin
    pwr_state_o = PWR_SLEEP;
    if (!fetch_q) begin
      pwr_state_o = PWR_OFF;
    end else if (busy_q || wake) begin
      pwr_state_o = PWR_ACTIVE;
    end else if (hold_active) begin
      pwr_state_o = PWR_HOLD;
    end
  end

endmodule

// File: rtl/cve2_pwr_ctrl.sv
// rtl/cve2_pwr_ctrl.sv - multi-hart clock-enable and sleep controller
module cve2_pwr_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned NumHarts          = 2,
  parameter int unsigned IdleHoldCycles    = 0,
  parameter bit          FetchEnableSticky = 1'b1,
  parameter int unsigned CntWidth          = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               test_en_i,
  input  logic [NumHarts-1:0]                fetch_enable_i,
  input  logic [NumHarts-1:0]                core_busy_i,
  input  logic [NumHarts-1:0]                irq_pending_i,
  input  logic [NumHarts-1:0]                irq_nm_i,
  input  logic [NumHarts-1:0]                debug_req_i,
  input  logic [NumHarts-1:0]                cnt_clr_i,
  output logic [NumHarts-1:0]                clk_o,
  output logic [NumHarts-1:0]                clk_en_o,
  output logic [NumHarts-1:0]                fetch_enable_o,
  output logic [NumHarts-1:0]                core_sleep_o,
  output logic                               all_sleep_o,
  output logic [NumHarts-1:0]                wake_o,
  output logic [NumHarts-1:0][1:0]           pwr_state_o,
  output logic [NumHarts-1:0][CntWidth-1:0]  sleep_cycles_o
);

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    pwr_state_e state;

    cve2_pwr_hart_ctrl #(
      .IdleHoldCycles   (IdleHoldCycles),
      .FetchEnableSticky(FetchEnableSticky),
      .CntWidth         (CntWidth)
    ) u_hart (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .fetch_enable_i (fetch_enable_i[h]),
      .core_busy_i    (core_busy_i[h]),
      .irq_pending_i  (irq_pending_i[h]),
      .irq_nm_i       (irq_nm_i[h]),
      .debug_req_i    (debug_req_i[h]),
      .cnt_clr_i      (cnt_clr_i[h]),
      .clk_en_o       (clk_en_o[h]),
      .fetch_enable_o (fetch_enable_o[h]),
      .core_sleep_o   (core_sleep_o[h]),
      .wake_o         (wake_o[h]),
      .pwr_state_o    (state),
      .sleep_cycles_o (sleep_cycles_o[h])
    );

    assign pwr_state_o[h] = state;

    cve2_clock_gate u_clock_gate (
      .clk_i    (clk_i),
      .en_i     (clk_en_o[h]),
      .test_en_i(test_en_i),
      .clk_o    (clk_o[h])
    );
  end

  // The only coupling between harts.
  assign all_sleep_o = &core_sleep_o;

endmodule

// File: tb/tb_cve2_pwr_ctrl.sv
// tb/tb_cve2_pwr_ctrl.sv - directed scoreboard bench for cve2_pwr_ctrl
module tb_cve2_pwr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic test_en = 1'b0;

  always #5 clk = ~clk;

  // Instance A: no hysteresis, sticky fetch, 4-bit counters
  logic [1:0] a_fe, a_busy, a_irq, a_nmi, a_dbg, a_clr;
  logic [1:0] a_clk, a_en, a_fe_o, a_slp, a_wake;
  logic       a_all;
  logic [1:0][1:0] a_st;
  logic [1:0][3:0] a_cnt;

  // Instance B: 4-cycle hysteresis, non-sticky fetch, 8-bit counters
  logic [1:0] b_fe, b_busy, b_irq, b_nmi, b_dbg, b_clr;
  logic [1:0] b_clk, b_en, b_fe_o, b_slp, b_wake;
  logic       b_all;
  logic [1:0][1:0] b_st;
  logic [1:0][7:0] b_cnt;

  cve2_pwr_ctrl #(
    .NumHarts(2), .IdleHoldCycles(0), .FetchEnableSticky(1'b1), .CntWidth(4)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .fetch_enable_i(a_fe), .core_busy_i(a_busy), .irq_pending_i(a_irq),
    .irq_nm_i(a_nmi), .debug_req_i(a_dbg), .cnt_clr_i(a_clr),
    .clk_o(a_clk), .clk_en_o(a_en), .fetch_enable_o(a_fe_o),
    .core_sleep_o(a_slp), .all_sleep_o(a_all), .wake_o(a_wake),
    .pwr_state_o(a_st), .sleep_cycles_o(a_cnt)
  );

  cve2_pwr_ctrl #(
    .NumHarts(2), .IdleHoldCycles(4), .FetchEnableSticky(1'b0), .CntWidth(8)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .fetch_enable_i(b_fe), .core_busy_i(b_busy), .irq_pending_i(b_irq),
    .irq_nm_i(b_nmi), .debug_req_i(b_dbg), .cnt_clr_i(b_clr),
    .clk_o(b_clk), .clk_en_o(b_en), .fetch_enable_o(b_fe_o),
    .core_sleep_o(b_slp), .all_sleep_o(b_all), .wake_o(b_wake),
    .pwr_state_o(b_st), .sleep_cycles_o(b_cnt)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] observe(input string t);
    case (t)
      "a.fe":   return 32'(a_fe_o);
      "a.en":   return 32'(a_en);
      "a.slp":  return 32'(a_slp);
      "a.wake": return 32'(a_wake);
      "a.all":  return 32'(a_all);
      "a.st0":  return 32'(a_st[0]);
      "a.st1":  return 32'(a_st[1]);
      "a.cnt0": return 32'(a_cnt[0]);
      "a.cnt1": return 32'(a_cnt[1]);
      "a.clk":  return 32'(a_clk);
      "b.fe":   return 32'(b_fe_o);
      "b.en":   return 32'(b_en);
      "b.slp":  return 32'(b_slp);
      "b.wake": return 32'(b_wake);
      "b.all":  return 32'(b_all);
      "b.st0":  return 32'(b_st[0]);
      "b.st1":  return 32'(b_st[1]);
      "b.cnt0": return 32'(b_cnt[0]);
      "b.clk":  return 32'(b_clk);
      default:  return 'x;
    endcase
  endfunction

  task automatic exp_(input string t, input logic [31:0] v);
    sb_item_t it;
    it.tag = t;
    it.exp = v;
    sb_q.push_back(it);
  endtask

  task automatic check_now();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      obs = observe(it.tag);
      n_vec++;
      assert (obs === it.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic settle();
    #4;
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_fe, a_busy, a_irq, a_nmi, a_dbg, a_clr} = '0;
    {b_fe, b_busy, b_irq, b_nmi, b_dbg, b_clr} = '0;

    #1 rst = 1'b1;
    #2;
    exp_("a.fe", 0); exp_("a.en", 0); exp_("a.slp", 0); exp_("a.wake", 0);
    exp_("a.all", 0); exp_("a.st0", 0); exp_("a.st1", 0); exp_("a.cnt0", 0);
    exp_("b.fe", 0); exp_("b.en", 0); exp_("b.slp", 0); exp_("b.all", 0);
    exp_("b.st0", 0); exp_("b.cnt0", 0);
    check_now();
    @(posedge clk);
    #1 rst = 1'b0;

    // c0: request fetch on hart 0 of both instances
    a_fe = 2'b01; a_busy = 2'b01; b_fe = 2'b01; b_busy = 2'b01;
    exp_("a.fe", 0); exp_("a.en", 0); exp_("b.fe", 0); exp_("b.st0", 0);
    settle();
    // c1
    a_fe = 2'b00;
    exp_("a.fe", 1); exp_("a.en", 1); exp_("a.st0", 1); exp_("a.st1", 0); exp_("a.slp", 0);
    exp_("b.fe", 1); exp_("b.en", 1); exp_("b.st0", 1);
    settle();
    // c2: clock was open during c1 low phase
    exp_("a.clk", 2'b01); check_now();
    a_busy = 2'b00; b_busy = 2'b00;
    exp_("a.en", 1); exp_("b.st0", 1);
    settle();
    // c3
    exp_("a.en", 0); exp_("a.slp", 1); exp_("a.st0", 3); exp_("a.all", 0); exp_("a.cnt0", 0);
    exp_("b.st0", 2); exp_("b.en", 1); exp_("b.slp", 0);
    settle();
    // c4
    exp_("a.cnt0", 1); exp_("b.st0", 2);
    settle();
    // c5: interrupt wakes A hart 0 in the same cycle
    a_irq = 2'b01;
    exp_("a.en", 1); exp_("a.wake", 1); exp_("a.st0", 1); exp_("a.slp", 0); exp_("a.cnt0", 2);
    exp_("b.st0", 2);
    settle();
    // c6
    a_irq = 2'b00; a_nmi = 2'b01;
    exp_("a.wake", 0); exp_("a.en", 1); exp_("b.st0", 2);
    settle();
    // c7: scan enable must not disturb clk_en
    a_nmi = 2'b00; test_en = 1'b1;
    exp_("a.en", 0); exp_("a.slp", 1); exp_("a.cnt0", 2);
    exp_("b.st0", 3); exp_("b.en", 0); exp_("b.slp", 1); exp_("b.cnt0", 0);
    settle();
    // c8
    exp_("a.clk", 2'b11); exp_("b.clk", 2'b11); check_now();
    test_en = 1'b0; b_dbg = 2'b01;
    exp_("b.st0", 1); exp_("b.en", 1); exp_("b.wake", 1); exp_("b.cnt0", 1); exp_("a.cnt0", 3);
    settle();
    // c9..c16: debug request during HOLD reloads the hysteresis
    b_dbg = 2'b00;
    exp_("b.st0", 2); exp_("b.wake", 0);
    settle();
    exp_("b.st0", 2);
    settle();
    b_dbg = 2'b01;
    exp_("b.st0", 1);
    settle();
    b_dbg = 2'b00;
    exp_("b.st0", 2);
    settle();
    settle();
    settle();
    exp_("b.st0", 2);
    settle();
    exp_("b.st0", 3); exp_("b.slp", 1);
    settle();
    // c17..c21: drain handshake in non-sticky mode
    b_busy = 2'b01;
    exp_("b.st0", 3);
    settle();
    b_fe = 2'b00;
    exp_("b.st0", 1); exp_("b.fe", 1);
    settle();
    b_busy = 2'b00;
    exp_("b.fe", 1); exp_("b.st0", 1);
    settle();
    exp_("b.fe", 1); exp_("b.st0", 2); exp_("b.en", 1);
    settle();
    exp_("b.fe", 0); exp_("b.st0", 0); exp_("b.en", 0); exp_("b.slp", 0); exp_("b.cnt0", 3);
    settle();
    // c22: wake sources ignored while off; A counter saturated
    b_irq = 2'b01;
    exp_("b.en", 0); exp_("b.wake", 0); exp_("b.st0", 0); exp_("a.cnt0", 15);
    settle();
    // c23: clear concurrent with sleep, enable A hart 1 idle
    a_clr = 2'b01; a_fe = 2'b10;
    exp_("a.cnt0", 15);
    settle();
    // c24
    a_clr = 2'b00; a_fe = 2'b00;
    exp_("a.cnt0", 0); exp_("a.slp", 2'b11); exp_("a.all", 1); exp_("a.st1", 3);
    settle();
    // c25
    exp_("a.cnt0", 1); exp_("a.cnt1", 1); exp_("a.all", 1);
    settle();

    // Asynchronous reset between edges with both A harts asleep
    #2 rst = 1'b1;
    #1;
    exp_("a.fe", 0); exp_("a.en", 0); exp_("a.slp", 0); exp_("a.all", 0); exp_("a.wake", 0);
    exp_("a.st0", 0); exp_("a.st1", 0); exp_("a.cnt0", 0); exp_("a.cnt1", 0);
    exp_("b.cnt0", 0); exp_("b.en", 0); exp_("b.fe", 0);
    check_now();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
